// File: rtl/sound_pkg.sv
// Shared types, tone table and priority picker for the sound arbiter.
package sound_pkg;

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  typedef logic [1:0] sound_id;
  localparam sound_id SND_CLICK = 2'd0;
  localparam sound_id SND_TUG   = 2'd1;
  localparam sound_id SND_WIN   = 2'd2;
  localparam sound_id SND_LOSE  = 2'd3;

  localparam int CNT_W = 28;
  typedef logic [CNT_W-1:0] cnt_t;

  // Unscaled cycle counts at 50 MHz, indexed by sound_id.
  localparam cnt_t HALF_PERIOD [4] = '{28'd25000, 28'd56818, 28'd28409, 28'd113636};
  localparam cnt_t DURATION    [4] = '{28'd2500000, 28'd10000000, 28'd25000000, 28'd25000000};

  typedef struct packed {
    logic    valid;
    sound_id id;
  } pick_t;

  function automatic pick_t prio_pick(input logic [3:0] p);
    pick_t r;
    r.valid = |p;
    r.id    = SND_CLICK;
    if (p[3])      r.id = SND_LOSE;
    else if (p[2]) r.id = SND_WIN;
    else if (p[1]) r.id = SND_TUG;
    return r;
  endfunction

  // Time-compressed constant; never collapses below one cycle.
  function automatic cnt_t scale(input cnt_t v, input int sh);
    cnt_t r;
    r = v >> sh;
    return (r == '0) ? cnt_t'(1) : r;
  endfunction

endpackage

// File: rtl/sound_arbiter_if.sv
// Game-side request/status bundle of the sound arbiter.
interface sound_arbiter_if;
  import sound_pkg::*;

  logic [3:0] req;
  logic       mute;
  logic       tone_out;
  logic       busy;
  logic [3:0] grant;
  sound_id    active_id;
  logic       done;

  modport master (output req, mute, input tone_out, busy, grant, active_id, done);
  modport slave  (input req, mute, output tone_out, busy, grant, active_id, done);
endinterface

// File: rtl/sound_arbiter_tone_gen.sv
// Square-wave generator: half-period counter, toggle and registered mute gate.
module tone_gen
  import sound_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  cnt_t half_m1,
  input  logic run,
  input  logic stop,
  input  logic mute,
  output logic tone_out
);

  cnt_t half_rld;
  cnt_t half_cnt;
  logic tone_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      half_rld <= '0;
      half_cnt <= '0;
      tone_raw <= 1'b0;
      tone_out <= 1'b0;
    end else begin
      if (load) begin
        half_rld <= half_m1;
        half_cnt <= half_m1;
        tone_raw <= 1'b0;
      end else if (stop) begin
        tone_raw <= 1'b0;
      end else if (run) begin
        if (half_cnt == '0) begin
          tone_raw <= ~tone_raw;
          half_cnt <= half_rld;
        end else begin
          half_cnt <= half_cnt - cnt_t'(1);
        end
      end
      tone_out <= tone_raw & ~mute;
    end
  end

endmodule

// File: rtl/sound_arbiter.sv
// Fixed-priority arbiter sharing one audio pin between four tone requesters.
// Define SOUND_PREEMPT_EN to let higher-priority requests abort a tone or gap.
module sound_arbiter
  import sound_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned GAP_CYCLES  = 2500000,
  parameter int          TIME_SHIFT  = 0
) (
  input logic            clk,
  input logic            reset,
  sound_arbiter_if.slave bus
);

  if (CLK_FREQ_HZ == 0) begin : g_clk_chk
    $error("CLK_FREQ_HZ must be nonzero");
  end

  localparam cnt_t GAP_M1 = scale(cnt_t'(GAP_CYCLES), TIME_SHIFT) - cnt_t'(1);

  state_t     state, state_n;
  logic [3:0] pending;
  logic [3:0] grant_n;
  cnt_t       dur_cnt, gap_cnt;
  pick_t      pk;
  logic       take, preempt;

  always_comb begin
    pk      = prio_pick(pending);
    preempt = 1'b0;
`ifdef SOUND_PREEMPT_EN
    preempt = (state != IDLE) && pk.valid && (pk.id > bus.active_id);
`else
    preempt = 1'b0;
`endif
    take    = preempt || ((state == IDLE) && pk.valid);
    grant_n = take ? (4'b0001 << pk.id) : 4'b0000;
    state_n = state;
    case (state)
      IDLE:    if (take) state_n = TONE;
      TONE:    if (preempt) state_n = TONE;
               else if (dur_cnt == '0) state_n = GAP;
      GAP:     if (preempt) state_n = TONE;
               else if (gap_cnt == '0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      pending       <= '0;
      dur_cnt       <= '0;
      gap_cnt       <= '0;
      bus.grant     <= '0;
      bus.active_id <= SND_CLICK;
      bus.done      <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      state     <= state_n;
      // A request landing on its own grant edge survives the clear.
      pending   <= (pending & ~grant_n) | bus.req;
      bus.grant <= grant_n;
      bus.busy  <= (state_n != IDLE);
      bus.done  <= 1'b0;
      if (take) begin
        bus.active_id <= pk.id;
        dur_cnt       <= scale(DURATION[pk.id], TIME_SHIFT) - cnt_t'(1);
      end else if (state == TONE) begin
        if (dur_cnt == '0) begin
          bus.done <= 1'b1;
          gap_cnt  <= GAP_M1;
        end else begin
          dur_cnt <= dur_cnt - cnt_t'(1);
        end
      end else if (state == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - cnt_t'(1);
      end
    end
  end

  tone_gen u_tone (
    .clk      (clk),
    .reset    (reset),
    .load     (take),
    .half_m1  (scale(HALF_PERIOD[pk.id], TIME_SHIFT) - cnt_t'(1)),
    .run      (state == TONE),
    .stop     ((state == TONE) && (dur_cnt == '0) && !take),
    .mute     (bus.mute),
    .tone_out (bus.tone_out)
  );

endmodule

// File: tb/tb_sound_arbiter.sv
// Directed bench for sound_arbiter at TIME_SHIFT=10 (click 24/2441, tug 55/9765, win 27/24414, lose 110/24414, gap 2441).
module tb_sound_arbiter;

  localparam int CLICK_D = 2441;
  localparam int TUG_D   = 9765;
  localparam int WIN_D   = 24414;
  localparam int LOSE_D  = 24414;
  localparam int GAP     = 2441;

  logic clk = 1'b0;
  logic reset = 1'b1;
  sound_arbiter_if bus();

  sound_arbiter #(.CLK_FREQ_HZ(50000000), .GAP_CYCLES(2500000), .TIME_SHIFT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int t = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    t++;
  endtask

  task automatic goto(input int tgt);
    while (t < tgt) tick();
  endtask

  task automatic pulse(input logic [3:0] r);
    bus.req = r;
    tick();
    bus.req = 4'b0000;
  endtask

  task automatic wait_grant(input int budget);
    int n = 0;
    while (bus.grant === 4'b0000 && n < budget) begin tick(); n++; end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (bus.done !== 1'b1 && n < budget) begin tick(); n++; end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.busy !== 1'b0 && n < budget) begin tick(); n++; end
  endtask

  initial begin
    int ts, t0, t1, t2, t3, highs, stray;
    bus.req  = 4'b0000;
    bus.mute = 1'b0;
    repeat (3) tick();
    check("rst_tone", bus.tone_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_grant", bus.grant, 0);
    check("rst_id", bus.active_id, 0);
    check("rst_done", bus.done, 0);
    reset = 1'b0;
    tick();

    // Single click: latency, waveform, done and gap timing.
    ts = t;
    pulse(4'b0001);
    wait_grant(10);
    check("click_lat", t - ts, 2);
    check("click_grant", bus.grant, 4'b0001);
    check("click_id", bus.active_id, 0);
    check("click_busy", bus.busy, 1);
    t0 = t;
    goto(t0 + 1);  check("click_grant_pulse", bus.grant, 0);
    goto(t0 + 24); check("click_t24", bus.tone_out, 0);
    goto(t0 + 25); check("click_t25", bus.tone_out, 1);
    goto(t0 + 48); check("click_t48", bus.tone_out, 1);
    goto(t0 + 49); check("click_t49", bus.tone_out, 0);
    goto(t0 + 72); check("click_t72", bus.tone_out, 0);
    goto(t0 + 73); check("click_t73", bus.tone_out, 1);
    wait_done(3000);
    check("click_done_t", t - t0, CLICK_D);
    check("click_busy_gap", bus.busy, 1);
    wait_idle(3000);
    check("click_idle_t", t - t0, CLICK_D + GAP);
    tick();
    check("click_no_regrant", bus.grant, 0);

    // win+tug together; extra tug pulses merge; tug re-request on its grant edge.
    ts = t;
    pulse(4'b0110);
    wait_grant(10);
    check("win_lat", t - ts, 2);
    check("win_grant", bus.grant, 4'b0100);
    check("win_id", bus.active_id, 2);
    t0 = t;
    goto(t0 + 100);  pulse(4'b0010);
    goto(t0 + 200);  pulse(4'b0010);
    goto(t0 + 5000); pulse(4'b0010);
    wait_done(30000);
    check("win_done_t", t - t0, WIN_D);
    check("win_busy_gap", bus.busy, 1);
    goto(t0 + WIN_D + GAP);
    check("win_idle", bus.busy, 0);
    pulse(4'b0010);
    check("tug1_grant", bus.grant, 4'b0010);
    check("tug1_id", bus.active_id, 1);
    t1 = t;
    wait_done(12000);
    check("tug1_done_t", t - t1, TUG_D);
    wait_grant(3000);
    check("tug2_grant_t", t - t1, TUG_D + GAP + 1);
    check("tug2_grant", bus.grant, 4'b0010);
    t2 = t;

    // Lose requested mid-tug, then played muted.
    goto(t2 + 1000);
    bus.mute = 1'b1;
    ts = t;
    pulse(4'b1000);
    wait_grant(15000);
`ifdef SOUND_PREEMPT_EN
    check("lose_preempt_lat", t - ts, 2);
`else
    check("lose_wait_t", t - t2, TUG_D + GAP + 1);
`endif
    check("lose_grant", bus.grant, 4'b1000);
    check("lose_id", bus.active_id, 3);
    t3 = t;
    highs = 0;
    while (bus.done !== 1'b1 && t - t3 < 30000) begin
      tick();
      if (bus.tone_out !== 1'b0) highs++;
    end
    check("lose_muted_highs", highs, 0);
    check("lose_done_t", t - t3, LOSE_D);
    wait_idle(3000);
    check("lose_idle_t", t - t3, LOSE_D + GAP);
    tick(); tick();
    check("no_leftover_grant", bus.grant, 0);
    check("no_leftover_busy", bus.busy, 0);
    bus.mute = 1'b0;

    // Reset in the middle of a win tone.
    pulse(4'b0100);
    wait_grant(10);
    check("win2_grant", bus.grant, 4'b0100);
    t0 = t;
    goto(t0 + 5000);
    reset = 1'b1;
    tick();
    check("mid_rst_tone", bus.tone_out, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_grant", bus.grant, 0);
    check("mid_rst_id", bus.active_id, 0);
    check("mid_rst_done", bus.done, 0);
    reset = 1'b0;
    stray = 0;
    repeat (20) begin
      tick();
      if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.done !== 1'b0) stray++;
    end
    check("post_rst_quiet", stray, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
